// File: rtl/apb_pkg.sv
// Shared definitions for the APB command master: FSM state encoding,
// default bus widths and the register map of the interconnect config/status
// block that this master normally talks to.
package apb_pkg;

    localparam int APB_ADDR_W         = 32;
    localparam int APB_DATA_W         = 32;
    localparam int APB_TIMEOUT_CYCLES = 16;

    // Config/status block base and register offsets
    localparam logic [31:0] APB_BASE   = 32'h5000_0000;
    localparam logic [7:0]  DECODE_ERR = 8'h00;
    localparam logic [7:0]  AW_SID     = 8'h04;
    localparam logic [7:0]  AR_SID     = 8'h08;
    localparam logic [7:0]  AW_CNT     = 8'h0C;
    localparam logic [7:0]  AR_CNT     = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

endpackage : apb_pkg

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog for the APB command master. Counts ACCESS cycles;
// 'expired' is high during the LIMIT-th ACCESS cycle of a transfer.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_timeout_cnt #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_r;

    assign expired = (cnt_r == CNT_W'(LIMIT - 1));

    // Cycle counter: cleared on load, advances per enabled cycle, saturates at expiry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en && !expired) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule : apb_timeout_cnt

// File: rtl/apb_cmd_master.sv
// APB requester: converts a valid/ready command stream into single APB
// transfers (one outstanding) and returns read data / error on a
// valid/ready response stream. Handles pready wait states and pslverr.
// Optional: APB_TIMEOUT_EN adds an ACCESS-phase watchdog that forces an
// error completion after TIMEOUT_CYCLES cycles without pready.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    apb_state_e        state_r;
    apb_state_e        state_nxt_s;
    logic              accept_s;
    logic              done_s;
    logic              err_s;
    logic [DATA_W-1:0] rdata_s;
    logic              timeout_s;

    logic              psel_r;
    logic              penable_r;
    logic              pwrite_r;
    logic [ADDR_W-1:0] paddr_r;
    logic [DATA_W-1:0] pwdata_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;

    // Ready only in IDLE and never while reset is asserted
    assign cmd_ready = rst_n && (state_r == ST_IDLE);

`ifdef APB_TIMEOUT_EN
    logic to_en_s;
    logic to_expired_s;

    assign to_en_s   = (state_r == ST_ACCESS);
    assign timeout_s = to_expired_s;

    apb_timeout_cnt #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept_s),
        .en      (to_en_s),
        .expired (to_expired_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic plus accept/complete strobes and completion result
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        done_s      = 1'b0;
        // A completion without pready can only be a watchdog expiry
        err_s       = pready ? pslverr : 1'b1;
        rdata_s     = (pwrite_r || err_s) ? {DATA_W{1'b0}} : prdata;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready wins over a simultaneous watchdog expiry via err_s
                if (pready || timeout_s) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Registered APB and response outputs; address/data held between transfers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            paddr_r     <= {ADDR_W{1'b0}};
            pwdata_r    <= {DATA_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            psel_r    <= (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS);
            penable_r <= (state_nxt_s == ST_ACCESS);
            if (accept_s) begin
                pwrite_r <= cmd_write;
                paddr_r  <= cmd_addr & WORD_MASK;
                pwdata_r <= cmd_write ? cmd_wdata : {DATA_W{1'b0}};
            end else begin
                pwrite_r <= pwrite_r;
                paddr_r  <= paddr_r;
                pwdata_r <= pwdata_r;
            end
            if (done_s) begin
                rsp_valid_r <= 1'b1;
                rsp_rdata_r <= rdata_s;
                rsp_err_r   <= err_s;
            end else if ((state_r == ST_RESP) && rsp_ready) begin
                rsp_valid_r <= 1'b0;
                rsp_rdata_r <= rsp_rdata_r;
                rsp_err_r   <= rsp_err_r;
            end else begin
                rsp_valid_r <= rsp_valid_r;
                rsp_rdata_r <= rsp_rdata_r;
                rsp_err_r   <= rsp_err_r;
            end
        end
    end

    assign psel      = psel_r;
    assign penable   = penable_r;
    assign pwrite    = pwrite_r;
    assign paddr     = paddr_r;
    assign pwdata    = pwdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule : apb_cmd_master

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed transfers drive the
// command side and play the APB completer; expected responses are queued
// at issue time and compared by a separate response monitor.
`timescale 1ns/1ps
module tb_apb_cmd_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;

    always #5 clk = ~clk;

    apb_cmd_master #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: pops the scoreboard on every response handshake
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rdata 0x%0h err %0b, expected no response", rsp_rdata, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
            end
        end
    end

    // One transfer: accept, SETUP, ACCESS with 'waits' wait states, RESP held 'hold' cycles
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] rdata, input logic slverr,
                           input int hold);
        logic [31:0] ea;
        logic [31:0] ewd;
        logic [31:0] erd;
        logic        eerr;
        logic        to;
        logic        last;
        int          acc;
        ea   = addr & 32'hFFFF_FFFC;
        ewd  = wr ? wdata : 32'h0;
        acc  = waits + 1;
        to   = 1'b0;
`ifdef APB_TIMEOUT_EN
        if (waits >= TO) begin
            acc = TO;
            to  = 1'b1;
        end
`endif
        eerr = to ? 1'b1 : slverr;
        erd  = (wr || eerr) ? 32'h0 : rdata;

        // cycle N: command accepted
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        exp_q.push_back('{rdata: erd, err: eerr});
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFFF;
        cmd_wdata = 32'h0BAD_F00D;

        // N+1: SETUP
        check("setup_psel", {31'd0, psel}, 32'd1);
        check("setup_penable", {31'd0, penable}, 32'd0);
        check("setup_pwrite", {31'd0, pwrite}, {31'd0, wr});
        check("setup_paddr", paddr, ea);
        check("setup_pwdata", pwdata, ewd);
        check("setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        tick();

        // N+2..: ACCESS; noise on pslverr/prdata while pready is low
        for (int i = 0; i < acc; i++) begin
            last    = !to && (i == acc - 1);
            pready  = last;
            pslverr = last ? slverr : 1'b1;
            prdata  = last ? rdata : 32'hDEAD_BEEF;
            check("access_psel", {31'd0, psel}, 32'd1);
            check("access_penable", {31'd0, penable}, 32'd1);
            check("access_paddr", paddr, ea);
            check("access_pwdata", pwdata, ewd);
            check("access_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0;

        // RESP: optional backpressure with the next command already waiting
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rsp_rdata", rsp_rdata, erd);
            check("hold_rsp_err", {31'd0, rsp_err}, {31'd0, eerr});
            check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("hold_psel", {31'd0, psel}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        check("resp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("resp_psel", {31'd0, psel}, 32'd0);
        check("resp_penable", {31'd0, penable}, 32'd0);
        check("resp_paddr_kept", paddr, ea);
        check("resp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        cmd_valid = 1'b0;
        check("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b1;
        prdata    = 32'h0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // Reset state
        tick();
        tick();
        tick();
        check("rst_psel", {31'd0, psel}, 32'd0);
        check("rst_penable", {31'd0, penable}, 32'd0);
        check("rst_pwrite", {31'd0, pwrite}, 32'd0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Read, zero wait states
        do_xfer(1'b0, 32'h5000_0004, 32'h1111_2222, 0, 32'hA1B2_C3D4, 1'b0, 0);
        // Write, 3 wait states
        do_xfer(1'b1, 32'h5000_0000, 32'h0000_0003, 3, 32'h7777_7777, 1'b0, 0);
        // Read with pslverr at completion (noise pslverr while waiting)
        do_xfer(1'b0, 32'h5000_0014, 32'h0, 2, 32'h9999_9999, 1'b1, 0);
        // Read with waits and noise pslverr, clean completion
        do_xfer(1'b0, 32'h5000_0008, 32'h0, 2, 32'h0000_0042, 1'b0, 0);
        // Write with pslverr
        do_xfer(1'b1, 32'h5000_000C, 32'hFEED_0001, 1, 32'h0, 1'b1, 0);
        // Unaligned read with 5 cycles of response backpressure, then back-to-back
        do_xfer(1'b0, 32'h5000_000E, 32'h0, 0, 32'h1234_5678, 1'b0, 5);
        do_xfer(1'b0, 32'h5000_0010, 32'h0, 0, 32'h0000_0007, 1'b0, 0);
        // pready on the 16th ACCESS cycle: normal in either build
        do_xfer(1'b1, 32'h5000_0004, 32'hABCD_EF01, TO - 1, 32'h0, 1'b0, 0);
        // pready low for 20 cycles: waits in default build, timeout error when enabled
        do_xfer(1'b0, 32'h5000_0008, 32'h0, 20, 32'h55AA_55AA, 1'b0, 0);

        // Reset during ACCESS aborts without a response
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h5000_000C;
        cmd_wdata = 32'h0000_00FF;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("abort_penable", {31'd0, penable}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("abort_psel", {31'd0, psel}, 32'd0);
        check("abort_penable_low", {31'd0, penable}, 32'd0);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("abort_rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
        do_xfer(1'b0, 32'h5000_0004, 32'h0, 1, 32'hCAFE_0001, 1'b0, 0);

        tick();
        tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_apb_cmd_master
